// File: rtl/alu_pkg.sv
// alu_pkg: function codes, multiply state encoding and default width for the execute result stage
package alu_pkg;
  localparam int DEF_WIDTH = 32;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_t;
  // Codes whose result comes straight from the ALU core
  function automatic logic is_alu_fn(input logic [5:0] fn);
    return fn == FN_ADD || fn == FN_SUB || fn == FN_AND || fn == FN_OR || fn == FN_SLT;
  endfunction
endpackage

// File: rtl/mul_seq.sv
// mul_seq: shift-add sequential unsigned multiplier, one product bit per cycle
module mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(MUL_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);
  mul_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0] sum;
  // State register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= MUL_IDLE;
    else state <= state_n;
  // Next state; a start outside IDLE is ignored, and the add keeps its carry in bit WIDTH
  always_comb begin
    state_n = (state == MUL_IDLE && start) ? MUL_RUN :
              (state == MUL_RUN && cnt == LAST) ? MUL_DONE :
              (state == MUL_DONE) ? MUL_IDLE : state;
    sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{prod[0]}} & mcand};
  end
  // Operand latch on start, then shift the partial product right each iteration
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt   <= '0;
      mcand <= '0;
      prod  <= '0;
    end else if (state == MUL_IDLE && start) begin
      mcand <= a;
      prod  <= {{WIDTH{1'b0}}, b};
      cnt   <= '0;
    end else if (state == MUL_RUN) begin
      prod <= {sum, prod[WIDTH-1:1]};
      cnt  <= cnt + 1'b1;
    end
  assign busy    = state != MUL_IDLE;
  assign done    = state == MUL_DONE;
  assign product = prod;
endmodule

// File: rtl/alu_out_stage.sv
// alu_out_stage: registers the selected execute result and holds the HI/LO multiply result pair
module alu_out_stage
  import alu_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] aluOut,
  input  logic [WIDTH-1:0] shiftOut,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy
);
  logic [WIDTH-1:0] hi, lo, sel;
  logic done;
  logic [2*WIDTH-1:0] product;
  mul_seq #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (Signal == FN_MULTU),
    .a       (dataA),
    .b       (dataB),
    .busy    (busy),
    .done    (done),
    .product (product)
  );
  // Result select; MULTU and unknown codes yield zero
  always_comb
    sel = is_alu_fn(Signal) ? aluOut :
          Signal == FN_SLL  ? shiftOut :
          Signal == FN_MFHI ? hi :
          Signal == FN_MFLO ? lo : '0;
  // Output register and HI/LO update; a read on the DONE edge still sees the old pair
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      dataOut <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      dataOut <= sel;
      if (done) {hi, lo} <= product;
    end
endmodule

// File: tb/tb_alu_out_stage.sv
// tb_alu_out_stage: scoreboard bench for the execute result stage and its multiplier
module tb_alu_out_stage;
  import alu_pkg::*;
  logic clk = 0;
  logic reset;
  logic [5:0] Signal;
  logic [31:0] aluOut, shiftOut, dataA, dataB, dataOut;
  logic busy;
  logic [31:0] sbq[$];
  int total = 0;
  int bad = 0;

  alu_out_stage dut (
    .clk(clk), .reset(reset), .Signal(Signal), .aluOut(aluOut), .shiftOut(shiftOut),
    .dataA(dataA), .dataB(dataB), .dataOut(dataOut), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc(input string tag, input logic [5:0] sig, input logic [31:0] alu, sh, a, b, exp);
    logic [31:0] e;
    Signal = sig; aluOut = alu; shiftOut = sh; dataA = a; dataB = b;
    sbq.push_back(exp);
    @(posedge clk); #1;
    e = sbq.pop_front();
    total++;
    if (dataOut !== e) begin
      bad++;
      $display("FAIL %s: dataOut=%h expected=%h", tag, dataOut, e);
    end
  endtask

  task automatic chk_busy(input string tag, input logic exp);
    total++;
    if (busy !== exp) begin
      bad++;
      $display("FAIL %s: busy=%b expected=%b", tag, busy, exp);
    end
  endtask

  task automatic run_mul(input string tag, input logic [31:0] a, b);
    int n = 0;
    logic [31:0] v;
    cyc({tag, " start"}, FN_MULTU, 32'h0, 32'h0, a, b, 32'h0);
    while (busy === 1'b1 && n < 100) begin
      n++;
      v = $urandom;
      cyc({tag, " add"}, FN_ADD, v, 32'h0, ~a, ~b, v);
    end
    total++;
    if (n != 33) begin
      bad++;
      $display("FAIL %s busy cycles: got %0d expected 33", tag, n);
    end
  endtask

  task automatic test_reset;
    reset = 0; Signal = FN_ADD; aluOut = 32'h1234; shiftOut = 0; dataA = 0; dataB = 0;
    #12;
    total++;
    if (dataOut !== 32'h0) begin
      bad++;
      $display("FAIL reset dataOut: got %h expected 00000000", dataOut);
    end
    chk_busy("reset busy", 1'b0);
    @(posedge clk); #1;
    reset = 1;
    cyc("release", FN_ADD, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h00001234);
  endtask

  task automatic test_select;
    logic [31:0] v;
    cyc("sll", FN_SLL, 32'hdead, 32'h80000000, 32'h0, 32'h0, 32'h80000000);
    cyc("slt", FN_SLT, 32'h1, 32'h5555, 32'h0, 32'h0, 32'h00000001);
    cyc("undef63", 6'd63, 32'hffff, 32'hffff, 32'h0, 32'h0, 32'h0);
    v = $urandom;
    cyc("sub", FN_SUB, v, ~v, 32'h0, 32'h0, v);
    cyc("and", FN_AND, 32'ha5a5a5a5, 32'h1, 32'h0, 32'h0, 32'ha5a5a5a5);
    cyc("or", FN_OR, 32'h0f0f0f0f, 32'h2, 32'h0, 32'h0, 32'h0f0f0f0f);
    cyc("undef1", 6'd1, 32'h3, 32'h3, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_mul_max;
    run_mul("max", 32'hffffffff, 32'hffffffff);
    cyc("max mfhi", FN_MFHI, 32'h0, 32'h0, 32'h0, 32'h0, 32'hfffffffe);
    cyc("max mflo", FN_MFLO, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000001);
  endtask

  task automatic test_mul_ignore;
    logic [31:0] v;
    cyc("ign start", FN_MULTU, 32'h0, 32'h0, 32'h00012345, 32'h00010000, 32'h0);
    chk_busy("ign busy e0", 1'b1);
    for (int e = 1; e <= 33; e++) begin
      if (e == 5 || e == 33) cyc("ign old lo", FN_MFLO, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000001);
      else if (e == 10) cyc("ign multu", FN_MULTU, 32'h0, 32'h0, 32'h7, 32'h9, 32'h0);
      else begin
        v = $urandom;
        cyc("ign add", FN_ADD, v, 32'h0, v, ~v, v);
      end
      if (e == 32) chk_busy("ign busy e32", 1'b1);
      if (e == 33) chk_busy("ign busy e33", 1'b0);
    end
    cyc("ign mfhi", FN_MFHI, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000001);
    chk_busy("ign no restart", 1'b0);
    cyc("ign mflo", FN_MFLO, 32'h0, 32'h0, 32'h0, 32'h0, 32'h23450000);
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    cyc("rm start", FN_MULTU, 32'h0, 32'h0, 32'h3, 32'h5, 32'h0);
    for (int e = 1; e <= 11; e++) begin
      v = $urandom;
      cyc("rm add", FN_ADD, v, 32'h0, 32'h0, 32'h0, v);
    end
    #3 reset = 0;
    #1;
    chk_busy("rm busy", 1'b0);
    total++;
    if (dataOut !== 32'h0) begin
      bad++;
      $display("FAIL rm dataOut: got %h expected 00000000", dataOut);
    end
    @(posedge clk); #1;
    reset = 1;
    cyc("rm mfhi", FN_MFHI, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    cyc("rm mflo", FN_MFLO, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    run_mul("fresh", 32'h3, 32'h5);
    cyc("fresh mflo", FN_MFLO, 32'h0, 32'h0, 32'h0, 32'h0, 32'd15);
    cyc("fresh mfhi", FN_MFHI, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back;
    int n = 0;
    logic [31:0] v;
    run_mul("b2b1", 32'h2, 32'h3);
    cyc("b2b2 start", FN_MULTU, 32'h0, 32'h0, 32'h0, 32'hffffffff, 32'h0);
    chk_busy("b2b2 accepted", 1'b1);
    cyc("b2b1 mflo", FN_MFLO, 32'h0, 32'h0, 32'h0, 32'h0, 32'd6);
    while (busy === 1'b1 && n < 100) begin
      n++;
      v = $urandom;
      cyc("b2b2 add", FN_ADD, v, 32'h0, 32'h1, 32'h1, v);
    end
    total++;
    if (n != 32) begin
      bad++;
      $display("FAIL b2b2 busy cycles: got %0d expected 32", n);
    end
    cyc("b2b2 mflo", FN_MFLO, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    cyc("b2b2 mfhi", FN_MFHI, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    test_reset;
    test_select;
    test_mul_max;
    test_mul_ignore;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_out_stage.md
# alu_out_stage

Result stage downstream of the barrel shifter and the ALU core in the MIPS-style execute unit. Registers the selected execute result (ALU or shifter output) onto a single 32-bit bus. Also contains the 32-cycle sequential unsigned multiplier (MULTU) and the HI/LO register pair read back by MFHI/MFLO.

## Interface
- WIDTH, 32: datapath width; HI/LO are WIDTH each, product 2×WIDTH.
- MUL_CYCLES, 32: multiply iterations; always equal to WIDTH.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low (0 = reset asserted).
- Signal  input  6  function code: ADD 32, SUB 34, AND 36, OR 37, SLT 42, SLL 0, MULTU 25, MFHI 16, MFLO 18.
- aluOut  input  WIDTH  combinational ALU core result.
- shiftOut  input  WIDTH  combinational shifter result.
- dataA  input  WIDTH  MULTU multiplicand.
- dataB  input  WIDTH  MULTU multiplier.
- dataOut  output  WIDTH  registered stage result.
- busy  output  1  high while a multiply is in progress.

## Operation
- dataOut is loaded every edge from a selection made on Signal:
  - ADD/SUB/AND/OR/SLT → aluOut.
  - SLL → shiftOut.
  - MFHI → hi; MFLO → lo.
  - MULTU or any undefined code → 0.
- Multiply FSM states are IDLE, RUN and DONE; busy = (state != IDLE).
- IDLE + Signal==MULTU:
  - mcand ← dataA.
  - prod[2W-1:0] ← {W'b0, dataB}.
  - cnt ← 0; go to RUN.
- RUN, each edge:
  - sum[W:0] = prod[2W-1:W] + (prod[0] ? mcand : 0), a 33-bit add with no carry lost.
  - prod ← {sum, prod[W-1:1]}; cnt ← cnt+1.
  - At cnt==MUL_CYCLES-1 go to DONE.
- DONE: {hi, lo} ← prod; go to IDLE.
- MULTU seen in RUN or DONE is ignored: no restart and operands are not re-latched.
- Non-multiply codes during RUN/DONE are served normally. MFHI/MFLO return the old hi/lo until the DONE edge.
- Result is exact unsigned 64-bit product; no overflow flag.
- dataA/dataB changes after the start edge have no effect on the product.

## Timing
- Reset values, applied asynchronously and held while reset=0:
  - dataOut=0, hi=0, lo=0, busy=0.
  - state=IDLE, cnt=0, prod=0, mcand=0.
- Reset mid-multiply aborts the operation; hi/lo become 0, not the partial product.
- ALU/shift/MFHI/MFLO latency: 1 cycle (input sampled at edge N, visible on dataOut after edge N).
- MULTU, sampled at edge 0:
  - busy rises after edge 0.
  - Iterations run on edges 1..32.
  - hi/lo are written on edge 33; busy falls after edge 33.
- MFHI sampled at edge 34 returns the new hi after edge 34.
- An MFHI sampled at edge 33 itself returns the old hi, because the read and the write share that edge.
- A back-to-back MULTU issued at edge 34 starts a new multiply; the earliest accepted restart is the first edge with busy=0.

## Structure
- Shared package `alu_pkg`:
  - function-code constants (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_MULTU, FN_MFHI, FN_MFLO);
  - multiply state enum;
  - WIDTH default.
- One natural sub-module, `mul_seq`: FSM, cnt, mcand, prod, busy, and a done pulse with the 64-bit product.
- Top level holds hi/lo and the dataOut select/register.

## Test plan
- Reset with Signal=ADD, aluOut=0x1234 → dataOut=0, busy=0. Release reset and hold 1 edge → dataOut=0x00001234.
- Signal=SLL, shiftOut=0x80000000, then Signal=SLT, aluOut=1 → dataOut 0x80000000 then 0x00000001 on consecutive edges. Undefined code 63 → dataOut=0.
- MULTU with dataA=0xFFFFFFFF, dataB=0xFFFFFFFF:
  - busy high for exactly 33 cycles.
  - Then MFHI → 0xFFFFFFFE, MFLO → 0x00000001.
- MULTU with dataA=0x00012345, dataB=0x00010000; MFLO issued at edge 5 and at edge 33 → old lo.
  - Issue a second MULTU with dataA=7, dataB=9 at edge 10; it is ignored.
  - After the multiply: MFHI → 0x00000001, MFLO → 0x23450000.
- Start MULTU 3×5 and assert reset at edge 12 → busy=0, hi=lo=0 immediately. A fresh MULTU 3×5 then gives MFLO=15, MFHI=0.
- Back-to-back multiplies 2×3, then 0×0xFFFFFFFF issued at the first idle edge → MFLO 6 after the first, then 0 after the second.
